// File: rtl/maze_store_if.sv
// Solver/loader bus of the maze store.
// slave  : the store (maze_store) side.
// master : the solver, loader and debug side.
// Signals: load_valid/load_data/load_ready   serial wall-plane load stream
//          maze_ready                        wall plane loaded, accesses honoured
//          row/col/maze_oe/maze_we/maze_in   solver cell access
//          vis_row/vis_col/vis_out           debug read of the visited plane
//          path_count                        distinct cells marked visited
//          clear                             wipe and reload request
interface maze_store_if #(
    parameter int maze_width = 6
);
    logic                    load_valid;
    logic                    load_data;
    logic                    load_ready;
    logic                    maze_ready;
    logic [maze_width-1:0]   row;
    logic [maze_width-1:0]   col;
    logic                    maze_oe;
    logic                    maze_we;
    logic                    maze_in;
    logic [maze_width-1:0]   vis_row;
    logic [maze_width-1:0]   vis_col;
    logic                    vis_out;
    logic [2*maze_width:0]   path_count;
    logic                    clear;

    modport slave (
        input  load_valid, load_data, row, col, maze_oe, maze_we,
               vis_row, vis_col, clear,
        output load_ready, maze_ready, maze_in, vis_out, path_count
    );

    modport master (
        output load_valid, load_data, row, col, maze_oe, maze_we,
               vis_row, vis_col, clear,
        input  load_ready, maze_ready, maze_in, vis_out, path_count
    );
endinterface

// File: rtl/maze_store.sv
// Maze memory for the maze solver.
// Holds a DIM x DIM wall plane (1 = wall) and a visited plane, DIM = 2**maze_width.
// After reset (or a clear in SERVE) the visited plane is wiped one cell per
// cycle, then the wall plane is loaded from a serial row-major stream, then
// solver reads (maze_oe) and mark-visited writes (maze_we) are served.
// Ports:
//   clk  in  single clock, all state changes on posedge
//   rst  in  asynchronous active-high reset
//   bus  maze_store_if.slave, see the interface file for the signal list
module maze_store #(
    parameter int maze_width = 6
) (
    input  logic          clk,
    input  logic          rst,
    maze_store_if.slave   bus
);
    localparam int unsigned CELLS = 2 ** (2 * maze_width);
    localparam logic [2*maze_width-1:0] LAST_IDX = '1;
    localparam logic [2*maze_width:0]   FULL     = (2*maze_width+1)'(CELLS);

    typedef enum logic [1:0] {CLR, LOAD, SERVE} state_t;

    state_t                  state;
    logic [2*maze_width-1:0] idx;
    logic [2*maze_width-1:0] addr;
    logic [2*maze_width-1:0] vis_addr;

    logic wall_mem [CELLS];
    logic vis_mem  [CELLS];

    logic                    load_beat;
    logic                    serve_we;
    logic                    vis_wr_en;
    logic [2*maze_width-1:0] vis_wr_addr;
    logic                    vis_wr_data;

    always_comb begin
        addr        = {bus.row, bus.col};
        vis_addr    = {bus.vis_row, bus.vis_col};
        load_beat   = (state == LOAD) && bus.load_valid;
        serve_we    = (state == SERVE) && bus.maze_we;
        // The visited plane has one write port shared by the CLR wipe and
        // solver marks; the two never coincide because they live in
        // different states.
        vis_wr_en   = (state == CLR) || serve_we;
        vis_wr_addr = (state == CLR) ? idx : addr;
        vis_wr_data = (state == SERVE);
    end

    // Storage planes carry no reset; CLR and LOAD initialise them.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            wall_mem[idx] <= bus.load_data;
        end
        if (vis_wr_en) begin
            vis_mem[vis_wr_addr] <= vis_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= CLR;
            idx            <= '0;
            bus.maze_in    <= 1'b0;
            bus.vis_out    <= 1'b0;
            bus.path_count <= '0;
            bus.load_ready <= 1'b0;
            bus.maze_ready <= 1'b0;
        end else begin
            bus.vis_out <= vis_mem[vis_addr];
            case (state)
                CLR: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx            <= '0;
                        state          <= LOAD;
                        bus.load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_beat) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            idx            <= '0;
                            state          <= SERVE;
                            bus.load_ready <= 1'b0;
                            bus.maze_ready <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (bus.maze_oe) begin
                        bus.maze_in <= wall_mem[addr];
                    end
                    // Count only first-time marks; the old bit is read before
                    // the write lands on this same edge.
                    if (bus.maze_we && !vis_mem[addr] && bus.path_count != FULL) begin
                        bus.path_count <= bus.path_count + 1'b1;
                    end
                    // clear overrides a same-cycle count: the plane is wiped anyway.
                    if (bus.clear) begin
                        state          <= CLR;
                        idx            <= '0;
                        bus.path_count <= '0;
                        bus.maze_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLR;
                    idx   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maze_store.sv
// Self-checking bench for maze_store: reset, clear/load sequencing, stalled
// load, solver reads through a scoreboard queue, visited marking and counting,
// and asynchronous reset in the middle of a load.
module tb_maze_store;
    localparam int W     = 6;
    localparam int DIM   = 64;
    localparam int CELLS = DIM * DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maze_store_if #(.maze_width(W)) bus();

    maze_store #(.maze_width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        logic  val;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [5:0] r;
        logic [5:0] c;
        logic       exp_a;
    } rd_vec_t;
    rd_vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic wall_model(input int pat, input int idx);
        int r;
        int c;
        r = idx / DIM;
        c = idx % DIM;
        if (pat == 0) return !(r == 5 && (c == 5 || c == 6));
        return ((r * 3 + c) % 5 == 0) || (r == DIM - 1) || (c == 0);
    endfunction

    task automatic read_cell(input int r, input int c, input logic exp, input string name);
        sb_t ent;
        @(negedge clk);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_oe = 1'b1;
        sb_q.push_back('{name, exp});
        @(posedge clk);
        #1;
        bus.maze_oe = 1'b0;
        ent = sb_q.pop_front();
        chk(ent.name, int'(bus.maze_in), int'(ent.val));
    endtask

    task automatic mark(input int r, input int c, input int exp_count, input string name);
        @(negedge clk);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_we = 1'b1;
        @(posedge clk);
        #1;
        bus.maze_we = 1'b0;
        chk(name, int'(bus.path_count), exp_count);
    endtask

    task automatic vis_chk(input int r, input int c, input logic exp, input string name);
        @(negedge clk);
        bus.vis_row = 6'(r);
        bus.vis_col = 6'(c);
        @(posedge clk);
        #1;
        chk(name, int'(bus.vis_out), int'(exp));
    endtask

    task automatic wait_load_ready(input string name);
        int cnt;
        bit mr_bad;
        cnt    = 0;
        mr_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.maze_ready) mr_bad = 1'b1;
        end while (!bus.load_ready && cnt < 6000);
        chk({name, "_clr_len"}, cnt, CELLS);
        chk({name, "_clr_maze_ready"}, int'(mr_bad), 0);
    endtask

    // stop_at < 0 loads all cells; poke drives oe/we/clear mid-load, which
    // the store must ignore outside SERVE.
    task automatic do_load(input int pat, input bit stall, input int stop_at,
                           input bit poke, input string name, output int cycles);
        int   beat;
        bit   rdy_bad;
        logic v;
        beat    = 0;
        cycles  = 0;
        rdy_bad = 1'b0;
        while (beat < CELLS && cycles < 20000) begin
            @(negedge clk);
            v = stall ? logic'(cycles % 2 == 1) : 1'b1;
            bus.load_valid = v;
            bus.load_data  = wall_model(pat, beat);
            if (poke && cycles == 50) begin
                bus.row     = 6'd5;
                bus.col     = 6'd7;
                bus.maze_oe = 1'b1;
                bus.maze_we = 1'b1;
            end else begin
                bus.maze_oe = 1'b0;
                bus.maze_we = 1'b0;
            end
            bus.clear = poke && cycles == 100;
            @(posedge clk);
            #1;
            cycles++;
            if (v) beat++;
            if (beat < CELLS && (!bus.load_ready || bus.maze_ready)) rdy_bad = 1'b1;
            if (stop_at >= 0 && beat >= stop_at) break;
        end
        bus.load_valid = 1'b0;
        bus.maze_oe    = 1'b0;
        bus.maze_we    = 1'b0;
        bus.clear      = 1'b0;
        chk({name, "_ready_during_load"}, int'(rdy_bad), 0);
        if (stop_at < 0) begin
            chk({name, "_maze_ready_after"}, int'(bus.maze_ready), 1);
            chk({name, "_load_ready_after"}, int'(bus.load_ready), 0);
        end
    endtask

    task automatic do_clear(input string name);
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        chk({name, "_path_count"}, int'(bus.path_count), 0);
        chk({name, "_maze_ready"}, int'(bus.maze_ready), 0);
        chk({name, "_load_ready"}, int'(bus.load_ready), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        sb_t ent;

        vt[0] = '{6'd0,  6'd0,  1'b1};
        vt[1] = '{6'd0,  6'd63, 1'b1};
        vt[2] = '{6'd63, 6'd0,  1'b1};
        vt[3] = '{6'd63, 6'd63, 1'b1};
        vt[4] = '{6'd5,  6'd5,  1'b0};
        vt[5] = '{6'd5,  6'd6,  1'b0};
        vt[6] = '{6'd5,  6'd7,  1'b1};
        vt[7] = '{6'd6,  6'd5,  1'b1};
        vt[8] = '{6'd5,  6'd4,  1'b1};
        vt[9] = '{6'd4,  6'd5,  1'b1};

        bus.load_valid = 1'b0;
        bus.load_data  = 1'b0;
        bus.row        = '0;
        bus.col        = '0;
        bus.maze_oe    = 1'b0;
        bus.maze_we    = 1'b0;
        bus.vis_row    = '0;
        bus.vis_col    = '0;
        bus.clear      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_ready", int'(bus.load_ready), 0);
        chk("rst_maze_ready", int'(bus.maze_ready), 0);
        chk("rst_maze_in",    int'(bus.maze_in), 0);
        chk("rst_vis_out",    int'(bus.vis_out), 0);
        chk("rst_path_count", int'(bus.path_count), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_load_ready("boot");

        // Unstalled load of pattern A, table-driven reads
        do_load(0, 1'b0, -1, 1'b0, "load_a", cyc);
        chk("load_a_cycles", cyc, CELLS);
        for (int i = 0; i < 10; i++)
            read_cell(int'(vt[i].r), int'(vt[i].c), vt[i].exp_a, $sformatf("rd_a_%0d", i));

        // maze_in holds while maze_oe=0 even though the address moves to a wall
        read_cell(5, 5, 1'b0, "rd_hold_pre");
        @(negedge clk);
        bus.row = 6'd5;
        bus.col = 6'd7;
        @(posedge clk);
        #1;
        chk("oe_hold", int'(bus.maze_in), 0);

        // Visited marking and counting
        mark(5, 5, 1, "we_55_first");
        mark(5, 5, 1, "we_55_again");
        mark(5, 6, 2, "we_56");
        vis_chk(5, 6, 1'b1, "vis_56");
        vis_chk(0, 0, 1'b0, "vis_00");
        vis_chk(5, 5, 1'b1, "vis_55");
        vis_chk(6, 5, 1'b0, "vis_65");

        // oe and we together
        @(negedge clk);
        bus.row = 6'd5; bus.col = 6'd7;
        bus.maze_oe = 1'b1; bus.maze_we = 1'b1;
        sb_q.push_back('{"oewe_57_in", 1'b1});
        @(posedge clk);
        #1;
        bus.maze_oe = 1'b0; bus.maze_we = 1'b0;
        ent = sb_q.pop_front();
        chk(ent.name, int'(bus.maze_in), int'(ent.val));
        chk("oewe_57_count", int'(bus.path_count), 3);
        @(negedge clk);
        bus.row = 6'd5; bus.col = 6'd5;
        bus.maze_oe = 1'b1; bus.maze_we = 1'b1;
        sb_q.push_back('{"oewe_55_in", 1'b0});
        @(posedge clk);
        #1;
        bus.maze_oe = 1'b0; bus.maze_we = 1'b0;
        ent = sb_q.pop_front();
        chk(ent.name, int'(bus.maze_in), int'(ent.val));
        chk("oewe_55_count", int'(bus.path_count), 3);
        read_cell(5, 7, 1'b1, "oewe_57_reread");
        read_cell(5, 5, 1'b0, "oewe_55_reread");

        // Mark every cell: count reaches DIM*DIM and stays there
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clk);
            bus.row = 6'(i / DIM);
            bus.col = 6'(i % DIM);
            bus.maze_we = 1'b1;
            @(posedge clk);
        end
        #1;
        bus.maze_we = 1'b0;
        chk("sweep_count", int'(bus.path_count), CELLS);
        mark(63, 63, CELLS, "sweep_sat");
        vis_chk(63, 63, 1'b1, "vis_6363");
        read_cell(5, 5, 1'b0, "pre_clear_rd");

        // clear, then stalled reload with ignored mid-load requests
        do_clear("clear1");
        wait_load_ready("clear1");
        do_load(0, 1'b1, -1, 1'b1, "load_stall", cyc);
        chk("load_stall_cycles", cyc, 2 * CELLS);
        chk("load_ignored_oe", int'(bus.maze_in), 0);
        chk("load_ignored_we", int'(bus.path_count), 0);
        for (int i = 0; i < 10; i++)
            read_cell(int'(vt[i].r), int'(vt[i].c), vt[i].exp_a, $sformatf("rd_stall_%0d", i));
        vis_chk(5, 7, 1'b0, "vis_57_after_clear");
        vis_chk(5, 5, 1'b0, "vis_55_after_clear");
        read_cell(5, 7, 1'b1, "pre_rst_rd");
        mark(1, 1, 1, "pre_rst_mark");

        // Asynchronous reset in the middle of a load
        do_clear("clear2");
        wait_load_ready("clear2");
        do_load(1, 1'b0, 1000, 1'b0, "load_part", cyc);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_load_ready", int'(bus.load_ready), 0);
        chk("midrst_maze_ready", int'(bus.maze_ready), 0);
        chk("midrst_maze_in",    int'(bus.maze_in), 0);
        chk("midrst_path_count", int'(bus.path_count), 0);
        chk("midrst_vis_out",    int'(bus.vis_out), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_load_ready("rst2");
        do_load(1, 1'b0, -1, 1'b0, "load_b", cyc);
        chk("load_b_cycles", cyc, CELLS);
        for (int i = 0; i < 10; i++)
            read_cell(int'(vt[i].r), int'(vt[i].c),
                      wall_model(1, int'(vt[i].r) * DIM + int'(vt[i].c)),
                      $sformatf("rd_b_%0d", i));
        read_cell(3, 1, wall_model(1, 3 * DIM + 1), "rd_b_31");
        read_cell(2, 2, wall_model(1, 2 * DIM + 2), "rd_b_22");
        vis_chk(1, 1, 1'b0, "vis_11_after_rst");
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
